// File: rtl/inst_fetch_bridge_pkg.sv
// Shared CPU-side definitions for the instruction fetch bridge: FSM encoding,
// the NOP word and the stop/enable levels used by the pipeline control signals.
package inst_fetch_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic        STOP         = 1'b1;
  localparam logic        NO_STOP      = 1'b0;
  localparam logic        CHIP_ENABLE  = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;
  localparam int          STALL_IFID   = 1;

endpackage

// File: rtl/inst_fetch_bridge_if.sv
// SRAM-like instruction bus: request/address toward the slave, address
// accept, read data and data-valid back toward the fetch bridge.
interface inst_fetch_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_data_ok;

  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_rdata, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_rdata, inst_data_ok
  );
endinterface

// File: rtl/inst_fetch_bridge.sv
// One-outstanding instruction fetch per PC: 3 cycles to a valid word with a zero-wait
// slave; stalls the pipeline until DONE and holds the word while IF/ID is stalled.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  input  logic [5:0]        stall_i,
  output logic              stallreq_o,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid_o,
  inst_fetch_bridge_if.master bus
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] inst_buf;
  logic              discard_r;
  logic              kill;
  logic              unused_stall;

  // A dropped enable is treated exactly like a redirect.
  assign kill         = flush_i | (ce_i == CHIP_DISABLE);
  assign unused_stall = ^{stall_i[5:2], stall_i[0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      addr_r    <= '0;
      inst_buf  <= DATA_W'(NOP_WORD);
      discard_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          discard_r <= 1'b0;
          if (ce_i == CHIP_ENABLE && !flush_i) begin
            addr_r <= pc_i;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (kill) discard_r <= 1'b1;
          if (bus.inst_addr_ok) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            if (discard_r || kill) begin
              discard_r <= 1'b0;
              state     <= S_IDLE;
            end else begin
              inst_buf <= bus.inst_rdata;
              state    <= S_DONE;
            end
          end else if (kill) begin
            discard_r <= 1'b1;
          end
        end
        S_DONE: begin
          if (kill) begin
            inst_buf <= DATA_W'(NOP_WORD);
            state    <= S_IDLE;
          end else if (!stall_i[STALL_IFID]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bus side is decoded from registers only; no path from inst_addr_ok to inst_req.
  assign bus.inst_req  = (state == S_REQ);
  assign bus.inst_addr = addr_r;

  // Gated by rst so the request drops the instant reset asserts.
  assign stallreq_o   = (rst && ce_i == CHIP_ENABLE && state != S_DONE) ? STOP : NO_STOP;
  assign inst_valid_o = (state == S_DONE);
  assign inst_o       = inst_valid_o ? inst_buf : DATA_W'(NOP_WORD);

endmodule
